exc_pipe_stage: RTL and testbench
=================================

Name: exc_pipe_stage

Overview:
- Parametrised successor to the fixed EX/MEM pipeline register for the exception-capable MIPS pipeline.
- Carries PC, instruction, branch-delay flag, exception code and a generic payload between any two stages.
- Adds valid/ready handshaking through a 2-entry skid buffer, a bubble flush, and an exception-request redirect that loads the handler PC.
- One instance per stage boundary (D/E, E/M, M/W).

Parameters:
DATA_W, 96, width of generic payload (e.g. ALU result, RD2, A2/A3, judge flags)
EXC_W, 5, exception code width
RESET_PC, 32'h0000_3000, PC presented on the output bubble after reset
HANDLER_PC, 32'h0000_4180, PC presented on the output bubble after req

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req  input  1  exception request: squash both entries, emit handler bubble
flush  input  1  squash both entries, emit bubble carrying in_pc
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry
in_pc  input  32  upstream PC
in_instr  input  32  upstream instruction
in_bd  input  1  upstream branch-delay flag
in_exc_code  input  EXC_W  upstream exception code (0 = none)
in_data  input  DATA_W  upstream payload
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts
out_pc  output  32  output PC (meaningful even when out_valid=0)
out_instr  output  32  output instruction
out_bd  output  1  output branch-delay flag
out_exc_code  output  EXC_W  output exception code
out_data  output  DATA_W  output payload
occ  output  2  occupancy, 0..2

Behaviour:
- Storage: main entry (drives outputs) and skid entry. States: EMPTY (occ=0), ONE (occ=1), FULL (occ=2). All outputs come from registers.
- out_valid = (state != EMPTY).
- in_ready = (state != FULL). It depends on state only, never combinationally on out_ready.
- Accept: acc = in_valid & in_ready. Issue: iss = out_valid & out_ready.
- EMPTY:
  - acc -> ONE, main <= input.
- ONE:
  - acc & iss -> ONE, main <= input.
  - acc & !iss -> FULL, skid <= input.
  - !acc & iss -> EMPTY.
  - otherwise hold.
- FULL:
  - iss -> ONE, main <= skid.
  - otherwise hold. No accept is possible.
- EMPTY bubble: out_instr = 0, out_data = 0, out_exc_code = 0, out_bd = 0. out_pc holds its last-loaded value (or the reset/req/flush value).
- Priority: reset > req > flush > normal handshake.
- req (at clock edge):
  - state <= EMPTY.
  - out_pc <= HANDLER_PC; all other main fields and skid cleared.
  - Any accept/issue offered in that cycle is discarded: no entry is stored. The downstream must not consume, since out_valid is registered and forced to 0 next cycle.
- flush (without req): as req, except out_pc <= in_pc and out_bd <= in_bd, so the bubble keeps the macroscopic PC for CP0.
- reset low (async):
  - state = EMPTY immediately, occ = 0, in_ready = 1.
  - out_pc = RESET_PC; all other outputs 0.
  - Reset asserted mid-transfer drops both entries.
- Fields travel together. exc_code and bd are never modified by the stage; first-exception priority is upstream's job.
- Latency: 1 cycle from accept to out_valid when EMPTY. Full throughput (1 entry/cycle) while out_ready=1.

Decomposition:
- Shared package pipe_pkg:
  - state enum (EMPTY/ONE/FULL);
  - constants RESET_PC, HANDLER_PC, EXC_NONE = 0;
  - packed entry struct {pc, instr, bd, exc_code, data}, width 65+EXC_W+DATA_W.
- One natural sub-module: pipe_entry_reg (one entry register with load/clear, async active-low reset and reset value parameter), instantiated for main and skid.

Test Plan:
- Reset low then high, no traffic -> out_valid=0, out_pc=0x3000, occ=0, in_ready=1, all other outputs 0.
- Stream of 4 entries with PC 0x3000,0x3004,0x3008,0x300C, out_ready=1 -> each appears 1 cycle after accept, in order, occ stays 1, no bubbles.
- out_ready=0, push 0x3000 then 0x3004 -> occ=2 and in_ready=0. A third push of 0x3008 is held off. Raise out_ready -> outputs 0x3000, 0x3004, then 0x3008, with no loss or duplication.
- FULL state, assert req with in_valid=1 (PC 0x3010) -> next cycle out_valid=0, out_pc=0x4180, occ=0, in_ready=1. Entry 0x3010 is not later emitted.
- ONE state, assert flush with in_pc=0x3020, in_bd=1 -> out_valid=0, out_pc=0x3020, out_bd=1, out_instr=0. req and flush together -> out_pc=0x4180.
- Entry with in_exc_code=5'd12, in_bd=1, DATA_W=96 payload all-ones -> emitted unchanged. Async reset asserted mid-cycle -> outputs clear before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the exception-capable pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam int          EXC_NONE   = 0;

    localparam int EXC_W_DEF  = 5;
    localparam int DATA_W_DEF = 96;

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            instr;
        logic                   bd;
        logic [EXC_W_DEF-1:0]   exc_code;
        logic [DATA_W_DEF-1:0]  data;
    } entry_t;

    function automatic int entry_w(input int data_w, input int exc_w);
        return 65 + exc_w + data_w;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry register with load, clear and a reset value.
module pipe_entry_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (ld_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/exc_pipe_stage.sv
// Parametrised pipeline stage register: 2-entry skid buffer with
// flush and exception redirect to the handler PC.
module exc_pipe_stage #(
    parameter int          DATA_W     = 96,
    parameter int          EXC_W      = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc_code,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc_code,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    import pipe_pkg::*;

    localparam int W     = entry_w(DATA_W, EXC_W);
    localparam int EXC_L = DATA_W;
    localparam int BD_B  = DATA_W + EXC_W;
    localparam int INS_L = BD_B + 1;
    localparam int PC_L  = INS_L + 32;

    localparam logic [EXC_W-1:0] EXC_CLR = EXC_W'(EXC_NONE);
    localparam logic [W-1:0] MAIN_RST =
        {RESET_PC, 32'h0, 1'b0, EXC_CLR, {DATA_W{1'b0}}};

    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] main_d;
    logic [W-1:0] skid_q;
    logic [W-1:0] in_ent;
    logic         main_ld;
    logic         skid_ld;
    logic         skid_clr;
    logic         acc;
    logic         iss;

    assign in_ent = {in_pc, in_instr, in_bd, in_exc_code, in_data};

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign occ       = state_q;

    assign acc = in_valid & in_ready;
    assign iss = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        main_ld  = 1'b0;
        main_d   = in_ent;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (req) begin
            state_d  = EMPTY;
            main_ld  = 1'b1;
            main_d   = {HANDLER_PC, 32'h0, 1'b0,
                        EXC_CLR, {DATA_W{1'b0}}};
            skid_clr = 1'b1;
        end else if (flush) begin
            state_d  = EMPTY;
            main_ld  = 1'b1;
            main_d   = {in_pc, 32'h0, in_bd,
                        EXC_CLR, {DATA_W{1'b0}}};
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_ld = 1'b1;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        acc & iss: begin
                            main_ld = 1'b1;
                        end
                        acc & ~iss: begin
                            state_d = FULL;
                            skid_ld = 1'b1;
                        end
                        ~acc & iss: begin
                            // Bubble keeps the PC of the entry just issued
                            state_d = EMPTY;
                            main_ld = 1'b1;
                            main_d  = {main_q[PC_L +: 32], 32'h0, 1'b0,
                                       EXC_CLR, {DATA_W{1'b0}}};
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (iss) begin
                        state_d  = ONE;
                        main_ld  = 1'b1;
                        main_d   = skid_q;
                        skid_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    pipe_entry_reg #(
        .W       (W),
        .RST_VAL (MAIN_RST)
    ) u_main (
        .clk   (clk),
        .rst_n (reset),
        .ld_i  (main_ld),
        .clr_i (1'b0),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_entry_reg #(
        .W       (W),
        .RST_VAL ('0)
    ) u_skid (
        .clk   (clk),
        .rst_n (reset),
        .ld_i  (skid_ld),
        .clr_i (skid_clr),
        .d_i   (in_ent),
        .q_o   (skid_q)
    );

    assign out_pc       = main_q[PC_L +: 32];
    assign out_instr    = main_q[INS_L +: 32];
    assign out_bd       = main_q[BD_B];
    assign out_exc_code = main_q[EXC_L +: EXC_W];
    assign out_data     = main_q[DATA_W-1:0];

endmodule

// File: tb/tb_exc_pipe_stage.sv
// Self-checking bench for exc_pipe_stage against a queue-based reference model.
module tb_exc_pipe_stage;

    localparam int DW = 96;
    localparam int EW = 5;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_bd;
    logic [EW-1:0] in_exc_code;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_bd;
    logic [EW-1:0] out_exc_code;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;

    exc_pipe_stage #(
        .DATA_W     (DW),
        .EXC_W      (EW),
        .RESET_PC   (32'h0000_3000),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .req          (req),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_bd        (in_bd),
        .in_exc_code  (in_exc_code),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_bd       (out_bd),
        .out_exc_code (out_exc_code),
        .out_data     (out_data),
        .occ          (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic          bd;
        logic [EW-1:0] exc;
        logic [DW-1:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] bub_pc;
    logic        bub_bd;
    int          n_chk;
    int          n_fail;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        bub_pc = 32'h0000_3000;
        bub_bd = 1'b0;
    endtask

    // Model of one clock edge, using the inputs currently driven
    task automatic model_step();
        ent_t e;
        bit   rdy;
        bit   take;
        e.pc = in_pc; e.instr = in_instr; e.bd = in_bd;
        e.exc = in_exc_code; e.data = in_data;
        if (req) begin
            mq.delete(); bub_pc = 32'h0000_4180; bub_bd = 1'b0;
        end else if (flush) begin
            mq.delete(); bub_pc = in_pc; bub_bd = in_bd;
        end else begin
            rdy  = (mq.size() < 2);
            take = in_valid && rdy;
            if (mq.size() > 0 && out_ready) begin
                bub_pc = mq[0].pc; bub_bd = 1'b0;
                void'(mq.pop_front());
            end
            if (take) mq.push_back(e);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 128'(out_valid), 128'(mq.size() != 0));
        chk({tag, ".occ"},   128'(occ),       128'(mq.size()));
        chk({tag, ".ready"}, 128'(in_ready),  128'(mq.size() < 2));
        if (mq.size() != 0) begin
            chk({tag, ".pc"},    128'(out_pc),       128'(mq[0].pc));
            chk({tag, ".instr"}, 128'(out_instr),    128'(mq[0].instr));
            chk({tag, ".bd"},    128'(out_bd),       128'(mq[0].bd));
            chk({tag, ".exc"},   128'(out_exc_code), 128'(mq[0].exc));
            chk({tag, ".data"},  128'(out_data),     128'(mq[0].data));
        end else begin
            chk({tag, ".pc"},    128'(out_pc),       128'(bub_pc));
            chk({tag, ".instr"}, 128'(out_instr),    128'(0));
            chk({tag, ".bd"},    128'(out_bd),       128'(bub_bd));
            chk({tag, ".exc"},   128'(out_exc_code), 128'(0));
            chk({tag, ".data"},  128'(out_data),     128'(0));
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic bd, input logic [EW-1:0] exc,
                         input logic [DW-1:0] data, input logic ordy,
                         input logic rq, input logic fl);
        in_valid = v; in_pc = pc; in_instr = pc ^ 32'hA5A5_0000;
        in_bd = bd; in_exc_code = exc; in_data = data;
        out_ready = ordy; req = rq; flush = fl;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic [31:0] pc,
                        input logic ordy);
        drive(1'b1, pc, 1'b0, '0, {3{pc}}, ordy, 1'b0, 1'b0);
        step(tag);
    endtask

    task automatic idle(input string tag, input logic ordy);
        drive(1'b0, 32'h0, 1'b0, '0, '0, ordy, 1'b0, 1'b0);
        step(tag);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #23;
        rst_n = 1'b1;
        #1;
        check_all("reset");
        idle("rst_idle", 1'b1);

        // Back-to-back stream with downstream always ready
        for (int i = 0; i < 4; i++) push("stream", 32'h3000 + 32'(4 * i), 1'b1);
        idle("stream_drain", 1'b1);

        // Fill both entries, third push held until drain
        push("bp0", 32'h3000, 1'b0);
        push("bp1", 32'h3004, 1'b0);
        push("bp2_held", 32'h3008, 1'b0);
        push("bp2_held", 32'h3008, 1'b0);
        push("bp_drain", 32'h3008, 1'b1);
        idle("bp_drain", 1'b1);
        idle("bp_drain", 1'b1);
        idle("bp_drain", 1'b1);

        // Exception redirect from FULL with a pending input
        push("full0", 32'h3000, 1'b0);
        push("full1", 32'h3004, 1'b0);
        drive(1'b1, 32'h3010, 1'b0, '0, '1, 1'b1, 1'b1, 1'b0);
        step("req_full");
        idle("req_after", 1'b1);
        idle("req_after", 1'b1);

        // Flush from ONE keeps PC and bd
        push("one", 32'h3018, 1'b0);
        drive(1'b0, 32'h3020, 1'b1, '0, '0, 1'b0, 1'b0, 1'b1);
        step("flush_one");
        idle("flush_after", 1'b1);
        push("one2", 32'h3024, 1'b0);
        drive(1'b1, 32'h3028, 1'b1, '0, '0, 1'b1, 1'b1, 1'b1);
        step("req_flush");

        // Exception code, bd and payload pass unchanged
        drive(1'b1, 32'h3030, 1'b1, 5'd12, '1, 1'b0, 1'b0, 1'b0);
        step("exc_in");
        idle("exc_out", 1'b1);

        // Async reset in mid-cycle clears outputs before next edge
        push("pre_rst", 32'h3040, 1'b0);
        push("pre_rst", 32'h3044, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle("rst_rel", 1'b1);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            logic [DW-1:0] d;
            d = {$urandom, $urandom, $urandom};
            drive(($urandom_range(0, 9) < 7),
                  {$urandom_range(0, 32'h3fff_ffff), 2'b00},
                  1'($urandom), 5'($urandom), d,
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 3));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
